sha3_msg_padder: RTL and testbench

//  Upstream feeder for the SHA3 permutation core: accepts a message as a stream of 64-bit words,

---
 rtl/sha3_msg_padder_pkg.sv | 34 +++
 rtl/sha3_pad_lane.sv | 33 +++
 rtl/sha3_msg_padder.sv | 160 ++++++++++++++++
 tb/tb_sha3_msg_padder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sha3_msg_padder_pkg.sv
// Shared constants, FSM encoding and block-layout helpers for the SHA3 message padder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha3_msg_padder_pkg;

    localparam int            SHA3_RATE_BITS  = 1088;
    localparam int            SHA3_RATE_WORDS = 17;
    localparam int            SHA3_LANE_BITS  = 64;
    localparam logic [7:0]    SHA3_DOM_SHA3   = 8'h06;
    localparam logic [7:0]    SHA3_DOM_SHAKE  = 8'h1F;
    localparam logic [7:0]    SHA3_LAST_BYTE  = 8'd135;
    localparam logic [7:0]    SHA3_RATE_BYTES = 8'd136;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_EMIT     = 2'd1,
        ST_EMIT_PAD = 2'd2
    } state_t;

    // Lane 0 occupies the most significant 64 bits of the block.
    function automatic int lane_msb(input int lane);
        return SHA3_RATE_BITS - 1 - SHA3_LANE_BITS * lane;
    endfunction

    // Block that carries only padding: domain byte at byte 0, terminator at byte 135.
    function automatic logic [SHA3_RATE_BITS-1:0] pad_only_block(input logic [7:0] dom);
        logic [SHA3_RATE_BITS-1:0] b;
        b = '0;
        b[lane_msb(0) - 56 -: 8] = dom;
        b[63:56]                 = 8'h80;
        return b;
    endfunction

endpackage

// File: rtl/sha3_pad_lane.sv
// One rate lane: keep message bytes below the pad position, zero the rest, OR in domain/terminator.
// Latency: combinational.
// Backpressure: none.
// Ports: lane_i source lane, pad_pos_i first non-message byte of the block (0..136),
//        pad_en_i insert padding, domain_i domain byte, lane_o resulting lane.
module sha3_pad_lane
    import sha3_msg_padder_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [63:0] lane_i,
    input  logic [7:0]  pad_pos_i,
    input  logic        pad_en_i,
    input  logic [7:0]  domain_i,
    output logic [63:0] lane_o
);

    for (genvar b = 0; b < 8; b++) begin : g_byte
        // Global byte index of this byte within the 136-byte block.
        localparam logic [7:0] G = 8'(LANE * 8 + b);

        logic [7:0] msg_byte;
        logic [7:0] dom_byte;
        logic [7:0] end_byte;

        assign msg_byte = (G < pad_pos_i) ? lane_i[8*b +: 8] : 8'h00;
        assign dom_byte = (pad_en_i && (G == pad_pos_i)) ? domain_i : 8'h00;
        assign end_byte = (pad_en_i && (G == SHA3_LAST_BYTE)) ? 8'h80 : 8'h00;
        // Domain and terminator may land on the same byte (0x06|0x80 = 0x86).
        assign lane_o[8*b +: 8] = msg_byte | dom_byte | end_byte;
    end

endmodule

// File: rtl/sha3_msg_padder.sv
// Packs 64-bit message words into 1088-bit rate blocks and applies pad10*1 with a domain byte.
// Latency: blk_valid_o rises the cycle after the edge that accepts the block-completing word.
// Backpressure: in_ready_o low while a block waits for blk_ready_i; one block in flight.
// Build option: define SHA3_PAD_SHAKE_EN to use the SHAKE domain byte 8'h1F instead of DOMAIN.
// Ports: clk_i, reset_i (async, active low); in_valid_i/in_ready_o/in_data_i/in_last_i/in_bytes_i
//        word input; blk_valid_o/blk_ready_i/blk_data_o/blk_last_o block output; busy_o.
module sha3_msg_padder
    import sha3_msg_padder_pkg::*;
#(
    parameter int         W          = 64,
    parameter int         RATE_WORDS = SHA3_RATE_WORDS,
    parameter logic [7:0] DOMAIN     = SHA3_DOM_SHA3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [W-1:0]            in_data_i,
    input  logic                    in_last_i,
    input  logic [3:0]              in_bytes_i,
    output logic                    blk_valid_o,
    input  logic                    blk_ready_i,
    output logic [W*RATE_WORDS-1:0] blk_data_o,
    output logic                    blk_last_o,
    output logic                    busy_o
);

    localparam int RB = W * RATE_WORDS;

`ifdef SHA3_PAD_SHAKE_EN
    localparam logic [7:0] DOM = SHA3_DOM_SHAKE;
`else
    localparam logic [7:0] DOM = DOMAIN;
`endif

    state_t          state_q, state_d;
    logic [4:0]      cnt_q;
    logic [RB-1:0]   blk_q;
    logic [RB-1:0]   pad_blk;
    logic            last_q;
    logic            spill_q;
    logic            rdy_q;

    logic            in_acc;
    logic            blk_xfer;
    logic [3:0]      n_eff;
    logic [7:0]      pad_pos;
    logic            pad_en;

    // A non-last word behaves like a last word of 8 bytes with padding suppressed,
    // so the same lane logic serves both the fill and the pad paths.
    assign n_eff   = !in_last_i ? 4'd8 : ((in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i);
    assign pad_pos = {cnt_q, 3'b000} + {4'b0000, n_eff};
    // A last word that exactly fills the block leaves no room: padding spills to a new block.
    assign pad_en  = in_last_i && (pad_pos != SHA3_RATE_BYTES);

    for (genvar j = 0; j < RATE_WORDS; j++) begin : g_lane
        logic [W-1:0] src;
        assign src = (cnt_q == 5'(j)) ? in_data_i : blk_q[lane_msb(j) -: W];

        sha3_pad_lane #(.LANE(j)) u_pad_lane (
            .lane_i    (src),
            .pad_pos_i (pad_pos),
            .pad_en_i  (pad_en),
            .domain_i  (DOM),
            .lane_o    (pad_blk[lane_msb(j) -: W])
        );
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (in_acc && (in_last_i || (cnt_q == 5'(RATE_WORDS - 1)))) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (blk_xfer) begin
                    state_d = spill_q ? ST_EMIT_PAD : ST_FILL;
                end
            end
            ST_EMIT_PAD: begin
                if (blk_xfer) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Output logic.
    always_comb begin
        in_ready_o  = rdy_q && (state_q == ST_FILL);
        blk_valid_o = (state_q != ST_FILL);
        blk_data_o  = blk_q;
        blk_last_o  = last_q;
        busy_o      = (state_q != ST_FILL) || (cnt_q != 5'd0);
    end

    assign in_acc   = in_valid_i && in_ready_o;
    assign blk_xfer = blk_valid_o && blk_ready_i;

    // Block buffer, word counter and flags.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            blk_q   <= '0;
            cnt_q   <= 5'd0;
            last_q  <= 1'b0;
            spill_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_FILL: begin
                    if (in_acc) begin
                        blk_q <= pad_blk;
                        cnt_q <= cnt_q + 5'd1;
                        if (in_last_i) begin
                            last_q  <= pad_en;
                            spill_q <= !pad_en;
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_xfer) begin
                        cnt_q <= 5'd0;
                        if (spill_q) begin
                            blk_q   <= pad_only_block(DOM);
                            last_q  <= 1'b1;
                            spill_q <= 1'b0;
                        end else begin
                            blk_q  <= '0;
                            last_q <= 1'b0;
                        end
                    end
                end
                ST_EMIT_PAD: begin
                    if (blk_xfer) begin
                        blk_q  <= '0;
                        last_q <= 1'b0;
                        cnt_q  <= 5'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_msg_padder.sv
// Directed bench for sha3_msg_padder: reset, padding positions, spill block, stall, mid-message reset.
// Latency: n/a.
// Backpressure: drives blk_ready_i explicitly, including a 10-cycle stall.
module tb_sha3_msg_padder;

`ifdef SHA3_PAD_SHAKE_EN
    localparam logic [7:0] DOM = 8'h1F;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif
    localparam logic [63:0] END_LANE = 64'h8000000000000000;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [63:0]   in_data_i;
    logic          in_last_i;
    logic [3:0]    in_bytes_i;
    logic          blk_valid_o;
    logic          blk_ready_i;
    logic [1087:0] blk_data_o;
    logic          blk_last_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    sha3_msg_padder dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_bytes_i  (in_bytes_i),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_data_o  (blk_data_o),
        .blk_last_o  (blk_last_o),
        .busy_o      (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_l [17];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msg_word(input int k);
        return {8'(k), 56'h11223344556677};
    endfunction

    function automatic logic [63:0] lane_of(input logic [1087:0] b, input int j);
        return b[1087 - 64*j -: 64];
    endfunction

    task automatic clear_exp();
        for (int j = 0; j < 17; j++) exp_l[j] = 64'h0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int t;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        in_bytes_i = nb;
        t = 0;
        while (!in_ready_o && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (!in_ready_o) check("send_ready_timeout", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic recv_block(input string tag, input logic exp_last);
        int t;
        t = 0;
        while (!blk_valid_o && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        check({tag, "_valid"}, 64'(blk_valid_o), 64'd1);
        for (int j = 0; j < 17; j++)
            check($sformatf("%s_lane%0d", tag, j), lane_of(blk_data_o, j), exp_l[j]);
        check({tag, "_last"}, 64'(blk_last_o), 64'(exp_last));
        blk_ready_i = 1'b1;
        @(posedge clk_i); #1;
        blk_ready_i = 1'b0;
    endtask

    initial begin
        logic [63:0] held;

        reset_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 64'h0;
        in_last_i   = 1'b0;
        in_bytes_i  = 4'd0;
        blk_ready_i = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_blk_valid", 64'(blk_valid_o), 64'd0);
        check("rst_blk_last", 64'(blk_last_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_lane0", lane_of(blk_data_o, 0), 64'h0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_in_ready", 64'(in_ready_o), 64'd1);

        // Empty message.
        send_word(64'hDEADBEEFDEADBEEF, 1'b1, 4'd0);
        check("empty_latency", 64'(blk_valid_o), 64'd1);
        clear_exp();
        exp_l[0]  = 64'(DOM);
        exp_l[16] = END_LANE;
        recv_block("empty", 1'b1);
        check("empty_valid_drop", 64'(blk_valid_o), 64'd0);
        check("empty_busy_idle", 64'(busy_o), 64'd0);

        // Three words, last one carries 5 bytes.
        send_word(msg_word(0), 1'b0, 4'd0);
        send_word(msg_word(1), 1'b0, 4'd0);
        check("w3_busy_mid", 64'(busy_o), 64'd1);
        send_word(msg_word(2), 1'b1, 4'd5);
        clear_exp();
        exp_l[0]  = 64'h0011223344556677;
        exp_l[1]  = 64'h0111223344556677;
        exp_l[2]  = 64'h0000003344556677 | (64'(DOM) << 40);
        exp_l[16] = END_LANE;
        recv_block("w3", 1'b1);

        // 17 full words: raw block then a pad-only block.
        for (int k = 0; k < 16; k++) send_word(msg_word(k), 1'b0, 4'd0);
        send_word(msg_word(16), 1'b1, 4'd8);
        for (int j = 0; j < 17; j++) exp_l[j] = msg_word(j);
        recv_block("spill_a", 1'b0);
        check("spill_valid_held", 64'(blk_valid_o), 64'd1);
        check("spill_in_ready", 64'(in_ready_o), 64'd0);
        clear_exp();
        exp_l[0]  = 64'(DOM);
        exp_l[16] = END_LANE;
        recv_block("spill_b", 1'b1);
        check("spill_valid_drop", 64'(blk_valid_o), 64'd0);

        // 16 full words + 7 bytes: domain and terminator share byte 135.
        for (int k = 0; k < 16; k++) send_word(msg_word(k), 1'b0, 4'd0);
        send_word(msg_word(16), 1'b1, 4'd7);
        for (int j = 0; j < 16; j++) exp_l[j] = msg_word(j);
        exp_l[16] = {(DOM | 8'h80), 56'h11223344556677};
        recv_block("w17_b7", 1'b1);

        // Stall: core holds blk_ready_i low for 10 cycles while input keeps offering words.
        send_word(msg_word(0), 1'b1, 4'd8);
        held = lane_of(blk_data_o, 0);
        in_valid_i = 1'b1;
        in_data_i  = 64'hFFFFFFFFFFFFFFFF;
        in_last_i  = 1'b1;
        in_bytes_i = 4'd3;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall_valid_c%0d", c), 64'(blk_valid_o), 64'd1);
            check($sformatf("stall_in_ready_c%0d", c), 64'(in_ready_o), 64'd0);
            check($sformatf("stall_lane0_c%0d", c), lane_of(blk_data_o, 0), held);
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        clear_exp();
        exp_l[0]  = 64'h0011223344556677;
        exp_l[1]  = 64'(DOM);
        exp_l[16] = END_LANE;
        recv_block("stall", 1'b1);
        check("stall_busy_idle", 64'(busy_o), 64'd0);

        // Reset during the ninth word of a message.
        for (int k = 0; k < 8; k++) send_word(msg_word(k), 1'b0, 4'd0);
        in_valid_i = 1'b1;
        in_data_i  = msg_word(8);
        #3;
        reset_i = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready_o), 64'd0);
        check("mid_rst_blk_valid", 64'(blk_valid_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_lane0", lane_of(blk_data_o, 0), 64'h0);
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        send_word(msg_word(0), 1'b1, 4'd3);
        clear_exp();
        exp_l[0]  = 64'h0000000000556677 | (64'(DOM) << 24);
        exp_l[16] = END_LANE;
        recv_block("after_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
